// File: rtl/sipo_deframer.sv
// Serial-to-parallel receive stage: start-bit detect, MSB-first shift, optional even parity,
// and a one-entry valid/ready output buffer that drops and flags frames when occupied.
module sipo_deframer #(
    parameter int WIDTH     = 3,
    parameter int PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             parity_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    logic [1:0]       state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] comp_word;
    logic             comp_perr;
    logic             complete;
    logic             buf_free;

    assign shifted  = {shreg[WIDTH-2:0], serial_in};
    assign buf_free = !out_valid || out_ready;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shreg_next = shreg;
        complete   = 1'b0;
        comp_word  = shifted;
        comp_perr  = 1'b0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    if (serial_in) begin
                        state_next = SHIFT;
                        cnt_next   = '0;
                    end
                end
                SHIFT: begin
                    shreg_next = shifted;
                    if (cnt == LAST) begin
                        if (PARITY_EN != 0) begin
                            state_next = PARITY;
                            cnt_next   = cnt + CW'(1);
                        end else begin
                            state_next = IDLE;
                            cnt_next   = '0;
                            complete   = 1'b1;
                            comp_word  = shifted;
                        end
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                PARITY: begin
                    // Even parity: XOR of data and parity bit must be zero.
                    state_next = IDLE;
                    cnt_next   = '0;
                    complete   = 1'b1;
                    comp_word  = shreg;
                    comp_perr  = (^shreg) ^ serial_in;
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            shreg <= shreg_next;
            busy  <= (state_next != IDLE);
        end
    end

    // A completion may refill the buffer on the same edge the consumer drains it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parallel_out <= '0;
            out_valid    <= 1'b0;
            parity_err   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (buf_free) begin
                    parallel_out <= comp_word;
                    parity_err   <= comp_perr;
                    out_valid    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed bench for sipo_deframer: one instance without parity and one with even parity,
// expected values computed by hand from the frame definitions.
module tb_sipo_deframer;

    logic       clk;
    logic       rst;

    logic       sin0, vld0, rdy0;
    logic [2:0] po0;
    logic       ov0, perr0, orun0, busy0;

    logic       sin1, vld1, rdy1;
    logic [2:0] po1;
    logic       ov1, perr1, orun1, busy1;

    int checks = 0;
    int errors = 0;

    sipo_deframer #(.WIDTH(3), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .serial_in(sin0), .in_valid(vld0),
        .parallel_out(po0), .out_valid(ov0), .out_ready(rdy0),
        .parity_err(perr0), .overrun(orun0), .busy(busy0)
    );

    sipo_deframer #(.WIDTH(3), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .serial_in(sin1), .in_valid(vld1),
        .parallel_out(po1), .out_valid(ov1), .out_ready(rdy1),
        .parity_err(perr1), .overrun(orun1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drives one bit into the selected instance, then returns #1 after the sampling edge.
    task automatic applyStimulus(input bit sel, input logic s, input logic v);
        if (sel) begin
            sin1 = s; vld1 = v; vld0 = 1'b0;
        end else begin
            sin0 = s; vld0 = v; vld1 = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input bit sel, input logic [7:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(sel, bits[i], 1'b1);
            if (i != 0) begin
                for (int g = 0; g < gap; g++) begin
                    applyStimulus(sel, 1'b0, 1'b0);
                    checkOutput("gap_busy", busy0, 1);
                end
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        sin0 = 1'b0; vld0 = 1'b0; rdy0 = 1'b0;
        sin1 = 1'b0; vld1 = 1'b0; rdy1 = 1'b0;

        // Reset with random inputs
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            sin0 = 1'($urandom); vld0 = 1'($urandom); rdy0 = 1'($urandom);
            sin1 = 1'($urandom); vld1 = 1'($urandom); rdy1 = 1'($urandom);
        end
        checkOutput("rst_po0",   po0,   0);
        checkOutput("rst_ov0",   ov0,   0);
        checkOutput("rst_perr0", perr0, 0);
        checkOutput("rst_orun0", orun0, 0);
        checkOutput("rst_busy0", busy0, 0);
        checkOutput("rst_po1",   po1,   0);
        checkOutput("rst_ov1",   ov1,   0);
        checkOutput("rst_perr1", perr1, 0);
        checkOutput("rst_orun1", orun1, 0);
        checkOutput("rst_busy1", busy1, 0);

        rdy0 = 1'b1; rdy1 = 1'b1;
        sin0 = 1'b0; vld0 = 1'b0; sin1 = 1'b0; vld1 = 1'b0;
        rst  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1'b0, 1'b1);
            checkOutput("idle_ov",   ov0,   0);
            checkOutput("idle_busy", busy0, 0);
        end

        // Single frame 1,1,0,1 -> 3'b101
        applyStimulus(0, 1'b1, 1'b1);
        checkOutput("start_busy", busy0, 1);
        applyStimulus(0, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, 1'b1);
        checkOutput("f1_po",   po0,   3'b101);
        checkOutput("f1_ov",   ov0,   1);
        checkOutput("f1_busy", busy0, 0);
        checkOutput("f1_perr", perr0, 0);
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("f1_drain_ov", ov0, 0);
        checkOutput("f1_keep_po",  po0, 3'b101);

        // Same frame with 2-cycle gaps between bits
        sendFrame(0, 8'b1101, 4, 2);
        checkOutput("gap_po", po0, 3'b101);
        checkOutput("gap_ov", ov0, 1);
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("gap_drain", ov0, 0);

        // Overrun: buffer full, second frame dropped
        rdy0 = 1'b0;
        sendFrame(0, 8'b1001, 4, 0);
        checkOutput("or_first_po", po0, 3'b001);
        checkOutput("or_first_ov", ov0, 1);
        sendFrame(0, 8'b1100, 4, 0);
        checkOutput("or_pulse", orun0, 1);
        checkOutput("or_po",    po0,   3'b001);
        checkOutput("or_ov",    ov0,   1);
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("or_pulse_end", orun0, 0);
        checkOutput("or_hold_po",   po0,   3'b001);
        rdy0 = 1'b1;
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("or_drain_ov", ov0, 0);

        // Simultaneous drain and completion
        rdy0 = 1'b0;
        sendFrame(0, 8'b1001, 4, 0);
        applyStimulus(0, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("sim_pre_po", po0, 3'b001);
        rdy0 = 1'b1;
        applyStimulus(0, 1'b1, 1'b1);
        checkOutput("sim_po",   po0,   3'b101);
        checkOutput("sim_ov",   ov0,   1);
        checkOutput("sim_orun", orun0, 0);
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("sim_drain", ov0,   0);
        checkOutput("sim_orun2", orun0, 0);

        // Reset mid-frame with a word buffered
        rdy0 = 1'b0;
        sendFrame(0, 8'b1001, 4, 0);
        applyStimulus(0, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 1'b1);
        checkOutput("mid_busy", busy0, 1);
        vld0 = 1'b0;
        rst = 1'b1;
        #2;
        checkOutput("mid_rst_ov",   ov0,   0);
        checkOutput("mid_rst_po",   po0,   0);
        checkOutput("mid_rst_busy", busy0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("mid_after_ov",   ov0,   0);
        checkOutput("mid_after_busy", busy0, 0);
        rdy0 = 1'b1;

        // Even parity instance
        rdy1 = 1'b1;
        sendFrame(1, 8'b11000, 5, 0);
        checkOutput("par_bad_po",   po1,   3'b100);
        checkOutput("par_bad_err",  perr1, 1);
        checkOutput("par_bad_ov",   ov1,   1);
        checkOutput("par_bad_busy", busy1, 0);
        sendFrame(1, 8'b11001, 5, 0);
        checkOutput("par_ok_po",   po1,   3'b100);
        checkOutput("par_ok_err",  perr1, 0);
        checkOutput("par_ok_orun", orun1, 0);
        sendFrame(1, 8'b11111, 5, 0);
        checkOutput("par_111_po",  po1,   3'b111);
        checkOutput("par_111_err", perr1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
